axis_dispatcher_mc: RTL and testbench



---
 rtl/axis_dispatcher_mc.sv | 217 +++++++++++++++++++++
 tb/tb_axis_dispatcher_mc.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_dispatcher_mc.sv
// -----------------------------------------------------------------------------
// axis_dispatcher_mc
//
// Multi-channel input dispatcher. Each of NUM_CH host write ports feeds its
// own FIFO. A round-robin arbiter selects one channel at a time and forwards
// that channel's packet onto a single AXI-Stream tx port. Arbitration happens
// at packet granularity, so packets from different channels never interleave.
// Every flit is tagged with tid = channel index and
// tdest = DEST_NODES[channel*DESTW +: DESTW].
//
// Optional feature (macro AXIS_DISPATCH_PKT_CNT_EN):
//   When the macro is defined, a pkt_cnt output is added. It holds one 16-bit
//   wrapping counter per channel, counting accepted tlast beats.
//
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   data_fifo_wen     per-channel write enable
//   data_fifo_wdata   per-channel write data, channel c at [c*DATAW +: DATAW]
//   data_last         per-channel end-of-packet flag for the written beat
//   data_fifo_rdy     per-channel "FIFO can accept a write" (registered)
//   axis_tx_*         AXI-Stream master: tvalid/tready/tdata/tlast/tid/tdest
//   pkt_cnt           (macro only) NUM_CH x 16-bit packet counters
// -----------------------------------------------------------------------------
module axis_dispatcher_mc #(
    parameter int DATAW      = 512,
    parameter int IDW        = 2,
    parameter int DESTW      = 4,
    parameter int NUM_CH     = 3,
    parameter int FIFO_DEPTH = 8,
    parameter logic [NUM_CH*DESTW-1:0] DEST_NODES = {4'd9, 4'd1, 4'd2}
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         data_fifo_wen,
    input  logic [NUM_CH*DATAW-1:0]   data_fifo_wdata,
    input  logic [NUM_CH-1:0]         data_last,
    output logic [NUM_CH-1:0]         data_fifo_rdy,
    output logic                      axis_tx_tvalid,
    input  logic                      axis_tx_tready,
    output logic [DATAW-1:0]          axis_tx_tdata,
    output logic                      axis_tx_tlast,
    output logic [IDW-1:0]            axis_tx_tid,
    output logic [DESTW-1:0]          axis_tx_tdest
`ifdef AXIS_DISPATCH_PKT_CNT_EN
    ,
    output logic [NUM_CH*16-1:0]      pkt_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    // Channel FIFOs: each entry is {last, data}.
    logic [DATAW:0]    mem     [NUM_CH][FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr  [NUM_CH];
    logic [AW-1:0]     rd_ptr  [NUM_CH];
    logic [CW-1:0]     count   [NUM_CH];
    logic [CW-1:0]     count_d [NUM_CH];
    logic [NUM_CH-1:0] push, pop, empty, rdy_q;

    // Arbiter state.
    state_t            state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     rr_q, rr_d;
    logic              done_q, done_d;   // last beat of the packet already loaded
    logic              load, accept;
    logic [DATAW:0]    head;
    logic              found;
    logic [GW-1:0]     pick;
    int                scan_idx;

    assign data_fifo_rdy = rdy_q;
    assign accept        = axis_tx_tvalid && axis_tx_tready;
    assign head          = mem[grant_q][rd_ptr[grant_q]];

    // The output register refills while the granted packet is still open and
    // either the register is empty or its beat is leaving this cycle.
    assign load = (state_q == SEND) && !done_q && !empty[grant_q] &&
                  (!axis_tx_tvalid || axis_tx_tready);

    // NOTE: every signal driven by always_comb gets a default first; a path
    // that skips an assignment would otherwise infer a latch.
    always_comb begin
        push = '0;
        pop  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            push[c]    = data_fifo_wen[c] && rdy_q[c];
            pop[c]     = load && (grant_q == GW'(c));
            empty[c]   = (count[c] == '0);
            count_d[c] = count[c] + CW'(push[c]) - CW'(pop[c]);
        end
    end

    // NOTE: the FIFO storage has no reset; only pointers and counts define
    // which entries are valid, so clearing the array would be wasted logic.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (push[c]) mem[c][wr_ptr[c]] <= {data_last[c], data_fifo_wdata[c*DATAW +: DATAW]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= '1;
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
                if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
                count[c] <= count_d[c];
                // Registered ready tracks the updated count, so a pop and a
                // blocked write on a full FIFO leave ready low that cycle.
                rdy_q[c] <= (count_d[c] != CW'(FIFO_DEPTH));
            end
        end
    end

    // Arbiter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            done_q  <= done_d;
        end
    end

    // Arbiter next state: round-robin scan from rr_q with wrap-around.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        done_d   = done_q;
        found    = 1'b0;
        pick     = '0;
        scan_idx = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            scan_idx = int'(rr_q) + i;
            if (scan_idx >= NUM_CH) scan_idx = scan_idx - NUM_CH;
            if (!found && !empty[scan_idx]) begin
                found = 1'b1;
                pick  = GW'(scan_idx);
            end
        end
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = SEND;
                    grant_d = pick;
                    done_d  = 1'b0;
                end
            end
            SEND: begin
                if (load && head[DATAW]) done_d = 1'b1;
                if (accept && axis_tx_tlast) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                    rr_d    = (grant_q == GW'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // One-entry output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            axis_tx_tvalid <= 1'b0;
            axis_tx_tdata  <= '0;
            axis_tx_tlast  <= 1'b0;
            axis_tx_tid    <= '0;
            axis_tx_tdest  <= '0;
        end else if (load) begin
            axis_tx_tvalid <= 1'b1;
            axis_tx_tdata  <= head[DATAW-1:0];
            axis_tx_tlast  <= head[DATAW];
            axis_tx_tid    <= IDW'(grant_q);
            axis_tx_tdest  <= DEST_NODES[32'(grant_q)*DESTW +: DESTW];
        end else if (accept) begin
            axis_tx_tvalid <= 1'b0;
        end
    end

`ifdef AXIS_DISPATCH_PKT_CNT_EN
    logic [15:0] pkt_cnt_q [NUM_CH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) pkt_cnt_q[c] <= '0;
        end else if (accept && axis_tx_tlast) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (grant_q == GW'(c)) pkt_cnt_q[c] <= pkt_cnt_q[c] + 16'd1;
            end
        end
    end

    always_comb begin
        pkt_cnt = '0;
        for (int c = 0; c < NUM_CH; c++) pkt_cnt[c*16 +: 16] = pkt_cnt_q[c];
    end
`endif

endmodule

// File: tb/tb_axis_dispatcher_mc.sv
// -----------------------------------------------------------------------------
// tb_axis_dispatcher_mc
//
// Scoreboard bench for axis_dispatcher_mc (default parameters). Stimulus
// pushes expected tx beats into exp_q; a negedge monitor pops and compares
// on every accepted beat and checks that held beats stay stable.
// -----------------------------------------------------------------------------
module tb_axis_dispatcher_mc;

    localparam int DATAW = 512;
    localparam int NCH   = 3;

    typedef struct {
        logic [DATAW-1:0] data;
        logic             last;
        logic [1:0]       id;
        logic [3:0]       dest;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NCH-1:0]       wen = '0;
    logic [NCH-1:0]       wl = '0;
    logic [DATAW-1:0]     wd [NCH];
    logic [NCH*DATAW-1:0] wdata;
    logic [NCH-1:0]       rdy;
    logic                 tvalid;
    logic                 tready = 1'b0;
    logic [DATAW-1:0]     tdata;
    logic                 tlast;
    logic [1:0]           tid;
    logic [3:0]           tdest;
`ifdef AXIS_DISPATCH_PKT_CNT_EN
    logic [NCH*16-1:0]    pkt_cnt;
    logic [15:0]          exp_cnt [NCH];
`endif

    assign wdata = {wd[2], wd[1], wd[0]};

    axis_dispatcher_mc dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .data_fifo_wen   (wen),
        .data_fifo_wdata (wdata),
        .data_last       (wl),
        .data_fifo_rdy   (rdy),
        .axis_tx_tvalid  (tvalid),
        .axis_tx_tready  (tready),
        .axis_tx_tdata   (tdata),
        .axis_tx_tlast   (tlast),
        .axis_tx_tid     (tid),
        .axis_tx_tdest   (tdest)
`ifdef AXIS_DISPATCH_PKT_CNT_EN
        ,
        .pkt_cnt         (pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q [$];
    beat_t pend [NCH][$];
    beat_t seq  [NCH][$];
    int    model_rr = 0;
    int    dest_tab [NCH] = '{2, 1, 9};

    task automatic check(input string name, input logic [DATAW-1:0] got, input logic [DATAW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [DATAW-1:0] rand_data();
        logic [DATAW-1:0] r;
        for (int i = 0; i < DATAW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic beat_t mk(input int c, input logic [DATAW-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        b.id   = 2'(c);
        b.dest = 4'(dest_tab[c]);
        return b;
    endfunction

    // ---------------- monitor ----------------
    logic             held = 1'b0;
    logic [DATAW-1:0] h_data;
    logic             h_last;
    logic [1:0]       h_id;
    logic [3:0]       h_dest;

    always @(negedge clk) begin
        if (!rst_n) begin
            held <= 1'b0;
`ifdef AXIS_DISPATCH_PKT_CNT_EN
            for (int c = 0; c < NCH; c++) exp_cnt[c] <= '0;
`endif
        end else begin
            if (held) begin
                check("hold_tvalid", DATAW'(tvalid), 1);
                check("hold_tdata",  tdata, h_data);
                check("hold_tlast",  DATAW'(tlast), DATAW'(h_last));
                check("hold_tid",    DATAW'(tid),   DATAW'(h_id));
                check("hold_tdest",  DATAW'(tdest), DATAW'(h_dest));
            end
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected got tid=%0d data=%0h exp no beat", tid, tdata);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("tx_tdata", tdata, e.data);
                    check("tx_tlast", DATAW'(tlast), DATAW'(e.last));
                    check("tx_tid",   DATAW'(tid),   DATAW'(e.id));
                    check("tx_tdest", DATAW'(tdest), DATAW'(e.dest));
`ifdef AXIS_DISPATCH_PKT_CNT_EN
                    if (e.last) exp_cnt[e.id] <= exp_cnt[e.id] + 16'd1;
`endif
                end
            end
            held   <= tvalid && !tready;
            h_data <= tdata;
            h_last <= tlast;
            h_id   <= tid;
            h_dest <= tdest;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr(input int c, input logic [DATAW-1:0] d, input logic l);
        wen[c] = 1'b1;
        wd[c]  = d;
        wl[c]  = l;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        wen = '0;
        wl  = '0;
    endtask

    // Reference arbitration: whole packets, round-robin from model_rr.
    task automatic schedule();
        int    sel;
        beat_t b;
        forever begin
            sel = -1;
            for (int i = 0; i < NCH; i++) begin
                int c;
                c = (model_rr + i) % NCH;
                if (sel < 0 && pend[c].size() > 0) sel = c;
            end
            if (sel < 0) break;
            do begin
                b = pend[sel].pop_front();
                exp_q.push_back(b);
            end while (!b.last);
            model_rr = (sel + 1) % NCH;
        end
    endtask

    task automatic wait_drain(input bit rnd);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        check("drain_timeout", DATAW'(exp_q.size()), 0);
        tready = 1'b1;
        repeat (4) tick();
    endtask

`ifdef AXIS_DISPATCH_PKT_CNT_EN
    task automatic check_cnt(input string name);
        for (int c = 0; c < NCH; c++) check(name, DATAW'(pkt_cnt[c*16 +: 16]), DATAW'(exp_cnt[c]));
    endtask
`endif

    // ---------------- test sequence ----------------
    initial begin
        logic [DATAW-1:0] x, y;
        for (int c = 0; c < NCH; c++) wd[c] = '0;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy",    DATAW'(rdy), 3'b111);
        check("rst_tvalid", DATAW'(tvalid), 0);
        check("rst_tdata",  tdata, 0);
        check("rst_tlast",  DATAW'(tlast), 0);
        check("rst_tid",    DATAW'(tid), 0);
        check("rst_tdest",  DATAW'(tdest), 0);
        rst_n = 1'b1;
        tick();

        // Single packet and first-beat latency.
        tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            x = rand_data();
            wr(0, x, k == 2);
            exp_q.push_back(mk(0, x, k == 2));
            tick();
            check("latency_tvalid", DATAW'(tvalid), (k == 2) ? 1 : 0);
        end
        tick(); check("b2b_tvalid", DATAW'(tvalid), 1);
        tick(); check("b2b_tvalid", DATAW'(tvalid), 1);
        model_rr = 1;
        wait_drain(0);

        // Round-robin fairness: two 2-beat packets per channel.
        tready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < NCH; c++) begin
                x = rand_data();
                wr(c, x, k[0]);
                pend[c].push_back(mk(c, x, k[0]));
            end
            tick();
        end
        schedule();
        wait_drain(0);

        // Backpressure mid-packet on ch2.
        tready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            x = rand_data();
            wr(2, x, k == 3);
            exp_q.push_back(mk(2, x, k == 3));
            tick();
        end
        tready = 1'b0;
        repeat (5) tick();
        tready = 1'b1;
        check("bp_resume", DATAW'(tvalid), 1);
        tick(); check("bp_resume", DATAW'(tvalid), 1);
        tick(); check("bp_resume", DATAW'(tvalid), 1);
        model_rr = 0;
        wait_drain(0);

        // Full FIFO on ch1 while ch0 holds the grant.
        tready = 1'b0;
        x = rand_data();
        wr(0, x, 1'b0);
        exp_q.push_back(mk(0, x, 1'b0));
        repeat (4) tick();
        for (int k = 0; k < 8; k++) begin
            y = rand_data();
            wr(1, y, k == 7);
            seq[1].push_back(mk(1, y, k == 7));
            tick();
        end
        check("full_rdy", DATAW'(rdy[1]), 0);
        wr(1, rand_data(), 1'b1);
        tick();
        check("full_drop_rdy", DATAW'(rdy[1]), 0);
        x = rand_data();
        wr(0, x, 1'b1);
        exp_q.push_back(mk(0, x, 1'b1));
        tick();
        while (seq[1].size() > 0) exp_q.push_back(seq[1].pop_front());
        model_rr = 2;
        wait_drain(0);

        // Starved mid-packet: ch0 idles, ch2 waits behind it.
        tready = 1'b1;
        x = rand_data();
        wr(0, x, 1'b0);
        exp_q.push_back(mk(0, x, 1'b0));
        tick();
        for (int k = 0; k < 3; k++) begin
            y = rand_data();
            wr(2, y, k == 2);
            seq[2].push_back(mk(2, y, k == 2));
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            check("starve_tvalid", DATAW'(tvalid), 0);
        end
        x = rand_data();
        wr(0, x, 1'b1);
        exp_q.push_back(mk(0, x, 1'b1));
        tick();
        while (seq[2].size() > 0) exp_q.push_back(seq[2].pop_front());
        model_rr = 0;
        wait_drain(0);

        // Reset mid-packet; ch0 packet first so the pointer is non-zero.
        x = rand_data();
        wr(0, x, 1'b1);
        exp_q.push_back(mk(0, x, 1'b1));
        tick();
        wait_drain(0);
        for (int k = 0; k < 4; k++) begin
            x = rand_data();
            wr(1, x, k == 3);
            exp_q.push_back(mk(1, x, k == 3));
            tick();
        end
        check("rst_mid_pre_tvalid", DATAW'(tvalid), 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_tvalid", DATAW'(tvalid), 0);
        check("rst_mid_rdy",    DATAW'(rdy), 3'b111);
        exp_q.delete();
        model_rr = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
`ifdef AXIS_DISPATCH_PKT_CNT_EN
        check_cnt("rst_pkt_cnt");
`endif
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < NCH; c += 2) begin
                x = rand_data();
                wr(c, x, k == 1);
                pend[c].push_back(mk(c, x, k == 1));
            end
            tick();
        end
        schedule();
        wait_drain(0);

        // Randomized rounds against the packet-level reference model.
        for (int r = 0; r < 25; r++) begin
            int maxlen = 0;
            tready = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                int npk = $urandom_range(0, 2);
                seq[c].delete();
                for (int p = 0; p < npk; p++) begin
                    int len = $urandom_range(1, 3);
                    for (int k = 0; k < len; k++) seq[c].push_back(mk(c, rand_data(), k == len - 1));
                end
                if (seq[c].size() > maxlen) maxlen = seq[c].size();
            end
            for (int k = 0; k < maxlen; k++) begin
                for (int c = 0; c < NCH; c++) begin
                    if (k < seq[c].size()) wr(c, seq[c][k].data, seq[c][k].last);
                end
                tick();
            end
            for (int c = 0; c < NCH; c++) begin
                while (seq[c].size() > 0) pend[c].push_back(seq[c].pop_front());
            end
            schedule();
            wait_drain(1);
        end
`ifdef AXIS_DISPATCH_PKT_CNT_EN
        check_cnt("end_pkt_cnt");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
